// File: rtl/stopwatch_input_ctrl.sv
// Stopwatch front end: synchronizes and debounces three raw buttons, then runs the
// IDLE/RUN/PAUSED control FSM and the divider that paces the downstream BCD counters.
module stopwatch_input_ctrl #(
    parameter int DB_CYCLES = 1000000,
    parameter int TICK_DIV  = 1000000
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic start_btn,
    input  logic stop_btn,
    input  logic lap_btn,
    output logic run,
    output logic tick,
    output logic clear,
    output logic lap_hold
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    // Button order in the vectors below: bit 0 start, bit 1 stop, bit 2 lap.
    logic [2:0]       w_raw;
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_db_level;
    logic [2:0]       r_db_level_d;
    logic [2:0]       r_press;
    logic [CNT_W-1:0] r_db_cnt [3];

    assign w_raw = {lap_btn, stop_btn, start_btn};

    // NOTE: every register is written with <= so all flops sample the same pre-edge values.
    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_db_level   <= '0;
            r_db_level_d <= '0;
            r_press      <= '0;
            for (int i = 0; i < 3; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1      <= w_raw;
            r_sync2      <= r_sync1;
            r_db_level_d <= r_db_level;
            r_press      <= r_db_level & ~r_db_level_d;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_db_level[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db_level[i] <= r_sync2[i];
                    r_db_cnt[i]   <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Stop wins over a coincident start, so a simultaneous start is discarded.
    logic w_start_p;
    logic w_stop_p;
    logic w_lap_p;

    assign w_stop_p  = r_press[1];
    assign w_start_p = r_press[0] & ~r_press[1];
    assign w_lap_p   = r_press[2];

    state_t           r_state;
    state_t           w_next_state;
    logic             r_lap_hold;
    logic             w_lap_next;
    logic             r_clear;
    logic             w_clear_next;
    logic             r_tick;
    logic [DIV_W-1:0] r_div;
    logic             w_counting;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_lap_next   = r_lap_hold;
        w_clear_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_p) w_next_state = RUN;
            end
            RUN: begin
                if (w_stop_p) w_next_state = PAUSED;
                if (w_lap_p)  w_lap_next   = ~r_lap_hold;
            end
            PAUSED: begin
                if (w_lap_p) w_lap_next = 1'b0;
                if (w_stop_p) begin
                    w_next_state = IDLE;
                    w_clear_next = 1'b1;
                    w_lap_next   = 1'b0;
                end else if (w_start_p) begin
                    w_next_state = RUN;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Counting only while staying in RUN keeps tick from ever landing outside RUN.
    assign w_counting = (r_state == RUN) && (w_next_state == RUN);

    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_lap_hold <= 1'b0;
            r_clear    <= 1'b0;
            r_tick     <= 1'b0;
            r_div      <= '0;
        end else begin
            r_state    <= w_next_state;
            r_lap_hold <= w_lap_next;
            r_clear    <= w_clear_next;
            r_tick     <= w_counting && (r_div == DIV_LAST);
            if (w_clear_next) begin
                r_div <= '0;
            end else if (w_counting) begin
                r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
            end
        end
    end

    assign run      = (r_state == RUN);
    assign tick     = r_tick;
    assign clear    = r_clear;
    assign lap_hold = r_lap_hold;

endmodule

// File: tb/tb_stopwatch_input_ctrl.sv
// Bench for stopwatch_input_ctrl: directed scenarios plus randomized button activity,
// every cycle compared against a window-based behavioural model of the stopwatch.
module tb_stopwatch_input_ctrl;

    localparam int DB   = 4;
    localparam int TDIV = 5;
    localparam int S_IDLE   = 0;
    localparam int S_RUN    = 1;
    localparam int S_PAUSED = 2;

    logic clk_100MHz;
    logic reset;
    logic start_btn;
    logic stop_btn;
    logic lap_btn;
    logic run;
    logic tick;
    logic clear;
    logic lap_hold;

    int n_checks;
    int n_fail;
    bit chk_en;

    stopwatch_input_ctrl #(
        .DB_CYCLES(DB),
        .TICK_DIV (TDIV)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .reset     (reset),
        .start_btn (start_btn),
        .stop_btn  (stop_btn),
        .lap_btn   (lap_btn),
        .run       (run),
        .tick      (tick),
        .clear     (clear),
        .lap_hold  (lap_hold)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a button's debounced level flips once the last DB
    // synchronized samples all disagree with it; the sample history is a bit window.
    bit [15:0] m_hist [3];
    bit [2:0]  m_level;
    bit [2:0]  m_level_d;
    bit [2:0]  m_press;
    int        m_state;
    int        m_div;
    bit        m_tick;
    bit        m_clear;
    bit        m_lap;

    task automatic model_step();
        bit [2:0] raw;
        bit p_start, p_stop, p_lap, flip;
        int nstate;
        raw = {lap_btn, stop_btn, start_btn};
        if (!reset) begin
            m_state = S_IDLE; m_div = 0; m_tick = 0; m_clear = 0; m_lap = 0;
            m_level = '0; m_level_d = '0; m_press = '0;
            for (int b = 0; b < 3; b++) m_hist[b] = '0;
            return;
        end
        p_stop  = m_press[1];
        p_start = m_press[0] && !p_stop;
        p_lap   = m_press[2];
        nstate  = m_state;
        m_clear = 0;
        case (m_state)
            S_IDLE: if (p_start) nstate = S_RUN;
            S_RUN: begin
                if (p_stop) nstate = S_PAUSED;
                if (p_lap)  m_lap = !m_lap;
            end
            default: begin
                if (p_lap) m_lap = 0;
                if (p_stop) begin
                    nstate = S_IDLE; m_clear = 1; m_lap = 0; m_div = 0;
                end else if (p_start) begin
                    nstate = S_RUN;
                end
            end
        endcase
        m_tick = 0;
        if (m_state == S_RUN && nstate == S_RUN) begin
            m_div  = (m_div + 1) % TDIV;
            m_tick = (m_div == 0);
        end
        m_state   = nstate;
        m_press   = m_level & ~m_level_d;
        m_level_d = m_level;
        for (int b = 0; b < 3; b++) begin
            flip = 1;
            for (int k = 1; k <= DB; k++) if (m_hist[b][k] == m_level[b]) flip = 0;
            if (flip) m_level[b] = !m_level[b];
            m_hist[b] = {m_hist[b][14:0], raw[b]};
        end
    endtask

    initial forever begin
        @(posedge clk_100MHz);
        model_step();
    end

    initial forever begin
        @(negedge clk_100MHz);
        if (chk_en) begin
            check("m_run",      run,      m_state == S_RUN);
            check("m_tick",     tick,     m_tick);
            check("m_clear",    clear,    m_clear);
            check("m_lap_hold", lap_hold, m_lap);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_100MHz);
    endtask

    int cnt;
    int w;

    initial begin
        n_checks = 0; n_fail = 0; chk_en = 0;
        reset = 1'b0; start_btn = 0; stop_btn = 0; lap_btn = 0;
        step(1);
        chk_en = 1;
        step(2);
        check("rst_run", run, 0);
        check("rst_outs", {tick, clear, lap_hold}, 3'b000);

        // Start held across reset release: pulse after 7 clocks, RUN from 8, ticks 13/18/23.
        reset = 1'b1; start_btn = 1;
        for (int k = 1; k <= 25; k++) begin
            step(1);
            check("s_hold_run",  run,  k >= 8);
            check("s_hold_tick", tick, (k == 13) || (k == 18) || (k == 23));
        end
        start_btn = 0;
        step(8);

        // Reset mid-run returns to IDLE without a clear pulse.
        reset = 1'b0;
        step(1);
        check("rst_mid_run",   run,   0);
        check("rst_mid_clear", clear, 0);
        reset = 1'b1;
        step(6);

        // Bouncing start: no press until it settles, then RUN 8 clocks after the final rise.
        for (int i = 0; i < 4; i++) begin
            start_btn = (i % 2 == 0);
            step(1); check("bounce_run", run, 0);
            step(1); check("bounce_run", run, 0);
        end
        start_btn = 1;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            check("bounce_settle_run", run, k >= 8);
        end
        start_btn = 0;
        step(10);

        // Stop pauses (no ticks), second stop clears and returns to IDLE.
        stop_btn = 1; step(10); stop_btn = 0; step(10);
        check("pause_run", run, 0);
        cnt = 0;
        for (int k = 0; k < 15; k++) begin step(1); cnt += int'(tick); end
        check("pause_no_tick", cnt, 0);
        stop_btn = 1;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin step(1); cnt += int'(clear); end
        check("stop_clear_pulses", cnt, 1);
        stop_btn = 0; step(8);
        check("idle_run", run, 0);
        check("idle_lap", lap_hold, 0);

        // Lap toggles while the divider keeps ticking.
        start_btn = 1; step(10); start_btn = 0; step(5);
        check("lap_run", run, 1);
        lap_btn = 1; step(10);
        check("lap_hold_on", lap_hold, 1);
        lap_btn = 0; step(6);
        lap_btn = 1; step(10);
        check("lap_hold_off", lap_hold, 0);
        lap_btn = 0;
        cnt = 0;
        for (int k = 0; k < 25; k++) begin step(1); cnt += int'(tick); end
        check("lap_ticks_25", cnt, 5);

        // Coincident start and stop in RUN: stop wins, so we are PAUSED (a stop then clears).
        start_btn = 1; stop_btn = 1; step(12);
        check("coinc_run", run, 0);
        start_btn = 0; stop_btn = 0; step(8);
        stop_btn = 1;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin step(1); cnt += int'(clear); end
        check("coinc_paused_clear", cnt, 1);
        stop_btn = 0; step(8);

        // Pause with the divider at 3, resume: tick two clocks after re-entering RUN.
        start_btn = 1; step(4); stop_btn = 1; step(20);
        start_btn = 0; stop_btn = 0; step(8);
        check("resume_paused", run, 0);
        start_btn = 1;
        w = 0;
        while (!run && w < 40) begin step(1); w++; end
        check("resume_enter", run, 1);
        step(1); check("resume_tick1", tick, 0);
        step(1); check("resume_tick2", tick, 1);
        start_btn = 0; step(8);

        // Randomized button activity with occasional resets.
        for (int it = 0; it < 800; it++) begin
            if ($urandom_range(0, 99) < 2) begin
                reset = 1'b0;
                step($urandom_range(1, 3));
                reset = 1'b1;
            end
            start_btn = ($urandom_range(0, 3) == 0);
            stop_btn  = ($urandom_range(0, 4) == 0);
            lap_btn   = ($urandom_range(0, 3) == 0);
            step($urandom_range(1, 14));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_input_ctrl.md
STOPWATCH_INPUT_CTRL -- requirements
Module: stopwatch_input_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 1000000, meaning consecutive stable clocks for a debounced level change (10 ms at 100 MHz).
REQ-002 SHALL have parameter TICK_DIV, default 1000000, meaning clocks per count tick (100 Hz at 100 MHz).
REQ-003 SHALL have port clk_100MHz, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning synchronous active-low reset.
REQ-005 SHALL have port start_btn, input, 1, meaning raw asynchronous start button (btnU).
REQ-006 SHALL have port stop_btn, input, 1, meaning raw asynchronous stop/clear button (btnD).
REQ-007 SHALL have port lap_btn, input, 1, meaning raw asynchronous lap button.
REQ-008 SHALL have port run, output, 1, meaning the stopwatch is counting.
REQ-009 SHALL have port tick, output, 1, meaning a one-cycle count-enable pulse for the downstream BCD counter chain.
REQ-010 SHALL have port clear, output, 1, meaning a one-cycle pulse that zeroes the downstream counters.
REQ-011 SHALL have port lap_hold, output, 1, meaning a level that freezes the displayed value while the counters keep running.

Function
REQ-012 SHALL pass each raw button through its own 2-flop synchronizer before any other use.
REQ-013 SHALL debounce each synchronized button: the debounced level takes the synchronized value only after that value has differed from it for DB_CYCLES consecutive clocks; any mismatch gap restarts the count.
REQ-014 SHALL size each debounce counter as $clog2(DB_CYCLES+1) bits, with no wrap; the counter saturates or clears only.
REQ-015 SHALL generate a registered one-cycle press pulse on each debounced 0->1 transition; a release generates no pulse; holding a button generates exactly one pulse.
REQ-016 SHALL produce the press pulse DB_CYCLES+3 clocks after a clean raw rising edge, with the state change taking effect one clock later.
REQ-017 SHALL implement FSM states IDLE, RUN and PAUSED; run=1 only in RUN.
REQ-018 SHALL transition IDLE on start press to RUN.
REQ-019 SHALL transition RUN on stop press to PAUSED.
REQ-020 SHALL transition PAUSED on start press to RUN, resuming the tick divider from its held count.
REQ-021 SHALL transition PAUSED on stop press to IDLE, pulsing clear for one cycle, zeroing the divider and clearing lap_hold.
REQ-022 SHALL ignore stop presses in IDLE and start presses in RUN.
REQ-023 SHALL toggle lap_hold on a lap press in RUN.
REQ-024 SHALL force lap_hold to 0 on a lap press in PAUSED.
REQ-025 SHALL ignore lap presses in IDLE.
REQ-026 SHALL let stop take priority when start and stop press pulses coincide; lap is evaluated independently in the same cycle against the current state.
REQ-027 SHALL count the tick divider 0..TICK_DIV-1 in $clog2(TICK_DIV) bits only while in RUN, wrap to 0, and hold its value otherwise.
REQ-028 SHALL register tick high for exactly one clock on each divider wrap; the first tick follows TICK_DIV clocks after entering RUN from IDLE, and tick is never asserted outside RUN.

Reset
REQ-029 SHALL, while reset=0 at a clock edge, set state IDLE, run=0, tick=0, clear=0 and lap_hold=0, and zero all synchronizer flops, debounce counters, debounced levels and the divider.
REQ-030 SHALL treat a button held at reset release as a new press once it has been debounced.
REQ-031 SHALL, on reset asserted mid-run, return to IDLE at the next edge without pulsing clear.

Verification (DB_CYCLES=4, TICK_DIV=5)
REQ-032 SHALL verify: start_btn held high from cycle 0 -> one start pulse at cycle 7; run=1 from cycle 8; tick pulses at cycles 13, 18, 23.
REQ-033 SHALL verify: start_btn bounces 1-0-1-0 every 2 cycles, then is held high -> no pulse during bouncing; exactly one pulse 7 cycles after the final rise.
REQ-034 SHALL verify: in RUN, stop press, then stop press again after release -> run=0 and no ticks in PAUSED; second press gives clear=1 for one cycle, state IDLE, lap_hold=0.
REQ-035 SHALL verify: in RUN, lap press twice -> lap_hold goes 1 then 0 while tick keeps pulsing every 5 cycles.
REQ-036 SHALL verify: start_btn and stop_btn rise together while in RUN -> state becomes PAUSED, not RUN.
REQ-037 SHALL verify: pause with divider at 3, then resume -> next tick 2 clocks after re-entering RUN.
